// File: rtl/queue_arbiter.sv
//------------------------------------------------------------------------------
// queue_arbiter : two-producer / one-consumer front end for an external queue.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module queue_arbiter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             req0,
  input  logic                             req1,
  input  logic [WIDTH-1:0]                 din0,
  input  logic [WIDTH-1:0]                 din1,
  output logic                             gnt0,
  output logic                             gnt1,
  input  logic                             rd_req,
  output logic                             rd_gnt,
  output logic                             rd_valid,
  output logic [WIDTH-1:0]                 rd_data,
  output logic                             q_enq,
  output logic                             q_deq,
  output logic [WIDTH-1:0]                 q_din,
  input  logic [WIDTH-1:0]                 q_dout,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             full,
  output logic                             empty
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

  typedef enum logic {
    OP_DEQ = 1'b0,
    OP_ENQ = 1'b1
  } op_e;

  logic [CW-1:0] r_count;
  logic          r_prio;     // 0: producer 0 wins a tie, 1: producer 1 wins
  op_e           r_last_op;
  logic          r_rd_valid;

  logic w_full;
  logic w_empty;
  logic w_enq_elig;
  logic w_deq_elig;
  logic w_do_enq;
  logic w_do_deq;
  logic w_gnt0;
  logic w_gnt1;

  assign w_full     = (r_count == c_DEPTH);
  assign w_empty    = (r_count == '0);
  assign w_enq_elig = (req0 | req1) & ~w_full;
  assign w_deq_elig = rd_req & ~w_empty;

  // On contention the operation type alternates against the last one issued.
  assign w_do_enq = nrst & w_enq_elig & (~w_deq_elig | (r_last_op == OP_DEQ));
  assign w_do_deq = nrst & w_deq_elig & (~w_enq_elig | (r_last_op == OP_ENQ));

  assign w_gnt0 = w_do_enq & req0 & (~req1 | ~r_prio);
  assign w_gnt1 = w_do_enq & req1 & (~req0 |  r_prio);

  assign gnt0     = w_gnt0;
  assign gnt1     = w_gnt1;
  assign rd_gnt   = w_do_deq;
  assign q_enq    = w_gnt0 | w_gnt1;
  assign q_deq    = w_do_deq;
  assign q_din    = w_gnt1 ? din1 : din0;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_valid ? q_dout : '0;
  assign count    = r_count;
  assign full     = w_full;
  assign empty    = w_empty;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count    <= '0;
      r_prio     <= 1'b0;
      r_last_op  <= OP_DEQ;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_do_deq;
      if (w_do_enq) begin
        r_count   <= r_count + 1'b1;
        r_last_op <= OP_ENQ;
      end else if (w_do_deq) begin
        r_count   <= r_count - 1'b1;
        r_last_op <= OP_DEQ;
      end
      if (w_gnt0) begin
        r_prio <= 1'b1;
      end else if (w_gnt1) begin
        r_prio <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_queue_arbiter.sv
//------------------------------------------------------------------------------
// tb_queue_arbiter : directed scenarios plus random traffic against a queue model.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_queue_arbiter;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int CW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, rd_req = 1'b0;
  logic [W-1:0]  din0 = '0, din1 = '0;
  logic          gnt0, gnt1, rd_gnt, rd_valid, q_enq, q_deq, full, empty;
  logic [W-1:0]  rd_data, q_din;
  logic [W-1:0]  q_dout;
  logic [CW-1:0] count;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int           m_count;
  bit           m_prio;
  bit           m_last_enq;
  bit           m_valid;
  logic [W-1:0] m_rdata;
  logic [W-1:0] m_data[$];

  // values observed during the most recent step
  logic         s_gnt0, s_gnt1, s_rdgnt, s_qenq, s_qdeq, s_rdv, s_empty, s_full;
  logic [W-1:0] s_qdin;
  int           s_count;

  // external queue storage driven by the DUT strobes
  logic [W-1:0] ext_q[$];

  always #5 clk = ~clk;

  queue_arbiter #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .nrst(nrst),
    .req0(req0), .req1(req1), .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .q_enq(q_enq), .q_deq(q_deq), .q_din(q_din), .q_dout(q_dout),
    .count(count), .full(full), .empty(empty)
  );

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ext_q.delete();
      q_dout <= '0;
    end else begin
      if (q_deq) begin
        if (ext_q.size() > 0) q_dout <= ext_q.pop_front();
        else                  q_dout <= '0;
      end
      if (q_enq) ext_q.push_back(q_din);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count    = 0;
    m_prio     = 1'b0;
    m_last_enq = 1'b0;
    m_valid    = 1'b0;
    m_rdata    = '0;
    m_data.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_count"},   32'(count),    32'd0);
    check_eq({tag, "_full"},    32'(full),     32'd0);
    check_eq({tag, "_empty"},   32'(empty),    32'd1);
    check_eq({tag, "_rdv"},     32'(rd_valid), 32'd0);
    check_eq({tag, "_rdata"},   32'(rd_data),  32'd0);
    check_eq({tag, "_grants"},  32'({gnt0, gnt1, rd_gnt}), 32'd0);
    check_eq({tag, "_strobes"}, 32'({q_enq, q_deq}),       32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    nrst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; rd_req = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("rst");
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0;
    nrst = 1'b1;
  endtask

  // One clock cycle: drive, check every output against the model, then advance.
  task automatic step(input bit r0, input bit r1, input logic [W-1:0] d0,
                      input logic [W-1:0] d1, input bit rr);
    bit           enq_ok, deq_ok, e_g0, e_g1;
    int           op;  // 0 idle, 1 enqueue, 2 dequeue
    logic [W-1:0] e_din;
    @(negedge clk);
    req0 = r0; req1 = r1; din0 = d0; din1 = d1; rd_req = rr;
    #1;
    enq_ok = (r0 || r1) && (m_count != D);
    deq_ok = rr && (m_count != 0);
    if (enq_ok && deq_ok) op = m_last_enq ? 2 : 1;
    else if (enq_ok)      op = 1;
    else if (deq_ok)      op = 2;
    else                  op = 0;
    e_g0  = (op == 1) && r0 && (!r1 || !m_prio);
    e_g1  = (op == 1) && r1 && (!r0 ||  m_prio);
    e_din = e_g1 ? d1 : d0;

    s_gnt0 = gnt0; s_gnt1 = gnt1; s_rdgnt = rd_gnt; s_qenq = q_enq; s_qdeq = q_deq;
    s_rdv = rd_valid; s_qdin = q_din; s_count = int'(count); s_empty = empty; s_full = full;

    check_eq("gnt0",   32'(gnt0),     32'(e_g0));
    check_eq("gnt1",   32'(gnt1),     32'(e_g1));
    check_eq("rd_gnt", 32'(rd_gnt),   32'(op == 2));
    check_eq("q_enq",  32'(q_enq),    32'(op == 1));
    check_eq("q_deq",  32'(q_deq),    32'(op == 2));
    check_eq("q_din",  32'(q_din),    32'(e_din));
    check_eq("count",  32'(count),    32'(m_count));
    check_eq("full",   32'(full),     32'(m_count == D));
    check_eq("empty",  32'(empty),    32'(m_count == 0));
    check_eq("rd_vld", 32'(rd_valid), 32'(m_valid));
    check_eq("rd_dat", 32'(rd_data),  m_valid ? 32'(m_rdata) : 32'd0);

    m_valid = (op == 2);
    if (op == 2) begin
      m_rdata    = m_data.pop_front();
      m_count    = m_count - 1;
      m_last_enq = 1'b0;
    end else if (op == 1) begin
      m_data.push_back(e_din);
      m_count    = m_count + 1;
      m_last_enq = 1'b1;
    end
    if (e_g0)      m_prio = 1'b1;
    else if (e_g1) m_prio = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    logic [W-1:0] exp_din[4];
    exp_din[0] = 4'd1; exp_din[1] = 4'd2; exp_din[2] = 4'd1; exp_din[3] = 4'd2;

    model_reset();
    apply_reset();

    // both producers contend from reset: round-robin until full
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 4'd1, 4'd2, 0);
      check_eq("rr_gnt0", 32'(s_gnt0), 32'((i % 2) == 0));
      check_eq("rr_gnt1", 32'(s_gnt1), 32'((i % 2) == 1));
      check_eq("rr_qdin", 32'(s_qdin), 32'(exp_din[i]));
      check_eq("rr_cnt",  32'(s_count), 32'(i));
    end
    step(1, 1, 4'd1, 4'd2, 0);
    check_eq("full_flag", 32'(s_full), 32'd1);
    check_eq("full_gnt",  32'({s_gnt0, s_gnt1}), 32'd0);

    // drain four entries
    for (int i = 0; i < 5; i++) begin
      step(0, 0, '0, '0, i < 4);
      if (i < 4) check_eq("drain_deq", 32'(s_qdeq), 32'd1);
      if (i > 0) check_eq("drain_vld", 32'(s_rdv),  32'd1);
    end
    check_eq("drain_cnt",   32'(s_count), 32'd0);
    check_eq("drain_empty", 32'(s_empty), 32'd1);

    // reach count 2 with last operation a dequeue, then contend
    for (int i = 0; i < 3; i++) step(1, 0, 4'(i + 5), '0, 0);
    step(0, 0, '0, '0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 4'(i + 9), '0, 1);
      check_eq("alt_enq", 32'(s_qenq), 32'((i % 2) == 0));
      check_eq("alt_deq", 32'(s_qdeq), 32'((i % 2) == 1));
      check_eq("alt_cnt", 32'(s_count), 32'(2 + (i % 2)));
    end

    // read from an empty queue
    apply_reset();
    step(0, 0, '0, '0, 1);
    check_eq("emp_rdgnt", 32'(s_rdgnt), 32'd0);
    check_eq("emp_qdeq",  32'(s_qdeq),  32'd0);
    step(0, 0, '0, '0, 0);
    check_eq("emp_rdv",   32'(s_rdv),   32'd0);

    // reset lands while a dequeue result is in flight
    for (int i = 0; i < 3; i++) step(1, 0, 4'(i + 3), '0, 0);
    step(0, 0, '0, '0, 1);
    #1;
    check_eq("mid_rdv_pre", 32'(rd_valid), 32'd1);
    #1;
    rd_req = 1'b0;
    nrst = 1'b0;
    #1;
    model_reset();
    check_eq("mid_rdv",   32'(rd_valid), 32'd0);
    check_eq("mid_cnt",   32'(count),    32'd0);
    check_eq("mid_empty", 32'(empty),    32'd1);
    @(negedge clk);
    nrst = 1'b1;
    step(0, 1, '0, 4'd7, 0);
    check_eq("mid_gnt1", 32'(s_gnt1), 32'd1);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) apply_reset();
      else step(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                $urandom_range(0, 99) < 45);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/queue_arbiter.md
QUEUE_ARBITER -- requirements
Module: queue_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the data width of every data port.
REQ-002 Parameter DEPTH, default 4, SHALL set the managed queue capacity in entries.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port nrst, input, 1, SHALL be the asynchronous, active-low reset.
REQ-005 Ports req0/req1, input, 1 each, SHALL be producer enqueue requests.
REQ-006 Ports din0/din1, input, WIDTH each, SHALL carry the producer data.
REQ-007 Ports gnt0/gnt1, output, 1 each, SHALL be combinational same-cycle producer grants.
REQ-008 Port rd_req, input, 1, SHALL be the consumer dequeue request.
REQ-009 Port rd_gnt, output, 1, SHALL be the combinational same-cycle consumer grant.
REQ-010 Port rd_valid, output, 1, SHALL mark that rd_data holds dequeued data.
REQ-011 Port rd_data, output, WIDTH, SHALL be the dequeued data.
REQ-012 Ports q_enq and q_deq, output, 1 each, SHALL be the queue enqueue and dequeue strobes.
REQ-013 Port q_din, output, WIDTH, SHALL be the queue write data.
REQ-014 Port q_dout, input, WIDTH, SHALL be the queue registered read data.
REQ-015 Port count, output, clog2(DEPTH+1), SHALL give the current occupancy.
REQ-016 Ports full and empty, output, 1 each, SHALL be the occupancy flags.

Function
REQ-017 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), combinationally.
REQ-018 The block SHALL issue at most one queue operation per cycle; q_enq and q_deq SHALL never both be 1.
REQ-019 Enqueue SHALL be eligible when (req0|req1) is 1 and full is 0; dequeue SHALL be eligible when rd_req is 1 and empty is 0.
REQ-020 With exactly one operation type eligible, that operation SHALL issue.
REQ-021 With both types eligible, the block SHALL issue the type opposite to register last_op, which SHALL record every issued operation and SHALL be unchanged in idle cycles.
REQ-022 Among producers, a lone requester SHALL be granted; when both request, the holder of register prio SHALL be granted.
REQ-023 After a grant to producer i, prio SHALL point to the other producer; prio SHALL be unchanged in cycles without an enqueue grant.
REQ-024 q_enq SHALL equal gnt0|gnt1, and q_din SHALL equal din of the granted producer (din0 when no grant).
REQ-025 q_deq SHALL equal rd_gnt.
REQ-026 rd_valid SHALL be 1 exactly one cycle after rd_gnt is 1, and SHALL be 0 otherwise.
REQ-027 rd_data SHALL equal q_dout when rd_valid is 1 and 0 otherwise.
REQ-028 count SHALL increment by 1 on q_enq, decrement by 1 on q_deq, and SHALL never wrap past DEPTH or below 0.
REQ-029 While full, producer requests SHALL receive no grant and SHALL stay pending; while empty, rd_req SHALL receive no grant.
REQ-030 Grants SHALL not depend on any request being held; requesters may drop a request at any cycle.

Reset
REQ-031 On nrst low, the block SHALL asynchronously set count=0, prio=producer 0, last_op=DEQ and rd_valid=0, giving outputs full=0, empty=1, rd_data=0, all grants 0 and all strobes 0.
REQ-032 Reset asserted mid-operation SHALL discard any in-flight rd_valid, and the first cycle after release SHALL arbitrate from the reset state.

Verification
REQ-033 The bench SHALL cover this case: req0=req1=1 for 4 cycles from reset with din0=1, din1=2 -> grants 0,1,0,1, q_din 1,2,1,2, count 1..4, then full=1 and both grants 0.
REQ-034 The bench SHALL cover this case: count=4 with rd_req=1 for 4 cycles -> q_deq each cycle, rd_valid in the 4 following cycles, and count reaching 0 with empty=1.
REQ-035 The bench SHALL cover this case: count=2 with req0=1 and rd_req=1 held, starting with last_op=DEQ -> operations alternate ENQ, DEQ, ENQ, DEQ and count stays within 2..3.
REQ-036 The bench SHALL cover this case: empty=1 with rd_req=1 -> rd_gnt=0, q_deq=0 and rd_valid=0.
REQ-037 The bench SHALL cover this case: nrst pulsed low mid-dequeue with count=3 -> rd_valid=0 immediately, count=0, empty=1, and the next req1 is granted.
